// File: rtl/cache_pkg.sv
// Shared definitions for the cache line controller: FSM encoding,
// write-policy codes and a constant log2 helper for derived widths.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        FILL    = 2'd2,
        LINE_WB = 2'd3
    } state_t;

    // Write-through, no-allocate: drop the line on a store.
    localparam int WP_INVALIDATE = 0;
    // Write-through, no-allocate: patch the hit word in place.
    localparam int WP_UPDATE     = 1;

    // Ceiling log2 for elaboration-time widths (values are powers of two here).
    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Line assembly buffer: one register per word, written one word at a
// time during a fill, read out in parallel as the full cache line.
module line_buffer
    import cache_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int WORDS  = 2,
    parameter int IDX_W  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [WORDS-1:0][DATA_W-1:0]  line
);

    // Capture the returned SRAM word into its slot; clear on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line <= '0;
        end else if (wr_en) begin
            line[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/cache_line_ctrl.sv
// Cache line controller between the MEM stage, the data cache and the
// SRAM controller: 0-cycle read hits, in-order multi-word line fills on
// a read miss, and write-through stores with a selectable cache policy.
module cache_line_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 2,
    parameter int CACHE_ADDR_W   = 18,
    parameter int WRITE_POLICY   = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADDR_W-1:0]                  address,
    input  logic [DATA_W-1:0]                  writeData,
    input  logic                               MEM_R_EN,
    input  logic                               MEM_W_EN,
    output logic                               ready,
    output logic [DATA_W-1:0]                  readData,
    input  logic [DATA_W-1:0]                  sram_readData,
    input  logic                               sram_ready,
    output logic [ADDR_W-1:0]                  sram_address,
    output logic [DATA_W-1:0]                  sram_writeData,
    output logic                               SRAM_readEn,
    output logic                               SRAM_writeEn,
    input  logic                               isHit,
    input  logic [DATA_W-1:0]                  cache_readData,
    output logic                               cache_writeEn,
    output logic [DATA_W*WORDS_PER_LINE-1:0]   cache_writeData,
    output logic                               cache_updateEn,
    output logic [CACHE_ADDR_W-1:0]            cache_address,
    output logic                               LRU_update,
    output logic                               invalidate
);

    localparam int BOFF_W = log2(DATA_W / 8);
    localparam int OFF_W  = log2(WORDS_PER_LINE);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    state_t                                  state, next_state;
    logic [OFF_W-1:0]                        word_cnt, cnt_next;
    logic                                    buf_we;
    logic [WORDS_PER_LINE-1:0][DATA_W-1:0]   line_q;
    logic [OFF_W-1:0]                        word_off;
    logic [ADDR_W-1:0]                       word_addr;
    logic [ADDR_W-1:0]                       fill_addr;

    assign word_off        = address[OFF_W+BOFF_W-1:BOFF_W];
    assign word_addr       = {address[ADDR_W-1:BOFF_W], {BOFF_W{1'b0}}};
    assign fill_addr       = {address[ADDR_W-1:OFF_W+BOFF_W], word_cnt, {BOFF_W{1'b0}}};
    assign cache_address   = address[CACHE_ADDR_W+BOFF_W-1:BOFF_W];
    assign cache_writeData = line_q;

    line_buffer #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS_PER_LINE),
        .IDX_W  (OFF_W)
    ) u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_we),
        .wr_idx  (word_cnt),
        .wr_data (sram_readData),
        .line    (line_q)
    );

    // State and fill word counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            word_cnt <= '0;
        end else begin
            state    <= next_state;
            word_cnt <= cnt_next;
        end
    end

    // Next-state decode and all outputs; stores take priority over loads.
    always_comb begin
        next_state     = state;
        cnt_next       = word_cnt;
        buf_we         = 1'b0;
        ready          = 1'b0;
        readData       = '0;
        LRU_update     = 1'b0;
        invalidate     = 1'b0;
        cache_updateEn = 1'b0;
        cache_writeEn  = 1'b0;
        SRAM_readEn    = 1'b0;
        SRAM_writeEn   = 1'b0;
        sram_address   = address;
        sram_writeData = '0;

        case (state)
            IDLE: begin
                if (MEM_W_EN) begin
                    next_state = WRITE;
                    if (WRITE_POLICY == WP_UPDATE) begin
                        if (isHit) begin
                            cache_updateEn = 1'b1;
                            LRU_update     = 1'b1;
                        end
                    end else begin
                        invalidate = 1'b1;
                    end
                end else if (MEM_R_EN) begin
                    if (isHit) begin
                        ready      = 1'b1;
                        readData   = cache_readData;
                        LRU_update = 1'b1;
                    end else begin
                        next_state = FILL;
                        cnt_next   = '0;
                    end
                end else begin
                    ready = 1'b1;
                end
            end

            WRITE: begin
                SRAM_writeEn   = 1'b1;
                sram_address   = word_addr;
                sram_writeData = writeData;
                if (sram_ready) begin
                    ready      = 1'b1;
                    next_state = IDLE;
                end
            end

            FILL: begin
                SRAM_readEn  = 1'b1;
                sram_address = fill_addr;
                if (sram_ready) begin
                    buf_we = 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        cnt_next   = '0;
                        next_state = LINE_WB;
                    end else begin
                        cnt_next = word_cnt + OFF_W'(1);
                    end
                end
            end

            LINE_WB: begin
                cache_writeEn = 1'b1;
                ready         = 1'b1;
                readData      = line_q[word_off];
                next_state    = IDLE;
            end

            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Directed bench for cache_line_ctrl. Three instances share the request
// and SRAM inputs: A (2 words, invalidate policy), B (8 words, update
// policy), C (4 words, invalidate policy). Inputs change on the falling
// edge and outputs are sampled 1 ns later.
module tb_cache_line_ctrl;

    logic        clk, rst;
    logic [31:0] address, writeData, sram_readData, cache_readData;
    logic        MEM_R_EN, MEM_W_EN, sram_ready, isHit;

    logic        ready_a, ready_b, ready_c;
    logic [31:0] readData_a, readData_b, readData_c;
    logic [31:0] sram_address_a, sram_address_b, sram_address_c;
    logic [31:0] sram_writeData_a, sram_writeData_b, sram_writeData_c;
    logic        SRAM_readEn_a, SRAM_readEn_b, SRAM_readEn_c;
    logic        SRAM_writeEn_a, SRAM_writeEn_b, SRAM_writeEn_c;
    logic        cache_writeEn_a, cache_writeEn_b, cache_writeEn_c;
    logic [63:0]  cache_writeData_a;
    logic [255:0] cache_writeData_b;
    logic [127:0] cache_writeData_c;
    logic        cache_updateEn_a, cache_updateEn_b, cache_updateEn_c;
    logic [17:0] cache_address_a, cache_address_b, cache_address_c;
    logic        LRU_update_a, LRU_update_b, LRU_update_c;
    logic        invalidate_a, invalidate_b, invalidate_c;

    int checks = 0;
    int passed = 0;

    cache_line_ctrl #(.WORDS_PER_LINE(2), .WRITE_POLICY(0)) dut_a (
        .clk(clk), .rst(rst), .address(address), .writeData(writeData),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .ready(ready_a), .readData(readData_a),
        .sram_readData(sram_readData), .sram_ready(sram_ready), .sram_address(sram_address_a),
        .sram_writeData(sram_writeData_a), .SRAM_readEn(SRAM_readEn_a), .SRAM_writeEn(SRAM_writeEn_a),
        .isHit(isHit), .cache_readData(cache_readData), .cache_writeEn(cache_writeEn_a),
        .cache_writeData(cache_writeData_a), .cache_updateEn(cache_updateEn_a),
        .cache_address(cache_address_a), .LRU_update(LRU_update_a), .invalidate(invalidate_a));

    cache_line_ctrl #(.WORDS_PER_LINE(8), .WRITE_POLICY(1)) dut_b (
        .clk(clk), .rst(rst), .address(address), .writeData(writeData),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .ready(ready_b), .readData(readData_b),
        .sram_readData(sram_readData), .sram_ready(sram_ready), .sram_address(sram_address_b),
        .sram_writeData(sram_writeData_b), .SRAM_readEn(SRAM_readEn_b), .SRAM_writeEn(SRAM_writeEn_b),
        .isHit(isHit), .cache_readData(cache_readData), .cache_writeEn(cache_writeEn_b),
        .cache_writeData(cache_writeData_b), .cache_updateEn(cache_updateEn_b),
        .cache_address(cache_address_b), .LRU_update(LRU_update_b), .invalidate(invalidate_b));

    cache_line_ctrl #(.WORDS_PER_LINE(4), .WRITE_POLICY(0)) dut_c (
        .clk(clk), .rst(rst), .address(address), .writeData(writeData),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .ready(ready_c), .readData(readData_c),
        .sram_readData(sram_readData), .sram_ready(sram_ready), .sram_address(sram_address_c),
        .sram_writeData(sram_writeData_c), .SRAM_readEn(SRAM_readEn_c), .SRAM_writeEn(SRAM_writeEn_c),
        .isHit(isHit), .cache_readData(cache_readData), .cache_writeEn(cache_writeEn_c),
        .cache_writeData(cache_writeData_c), .cache_updateEn(cache_updateEn_c),
        .cache_address(cache_address_c), .LRU_update(LRU_update_c), .invalidate(invalidate_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        address = '0; writeData = '0; MEM_R_EN = 0; MEM_W_EN = 0;
        sram_readData = '0; sram_ready = 0; isHit = 0; cache_readData = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 0;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        @(negedge clk); #1;
        checks++; if (ready_a !== 1'b1) $display("FAIL rst_ready got %0b want 1", ready_a); else passed++;
        checks++; if ({SRAM_readEn_a, SRAM_writeEn_a, cache_writeEn_a, cache_updateEn_a} !== 4'b0)
            $display("FAIL rst_enables got %b want 0000", {SRAM_readEn_a, SRAM_writeEn_a, cache_writeEn_a, cache_updateEn_a}); else passed++;
        checks++; if ({invalidate_a, LRU_update_a} !== 2'b0) $display("FAIL rst_inv_lru got %b want 00", {invalidate_a, LRU_update_a}); else passed++;
        checks++; if (cache_writeData_a !== 64'h0) $display("FAIL rst_buffer got %h want 0", cache_writeData_a); else passed++;
        rst = 1;
    endtask

    task automatic test_hit();
        do_reset();
        @(negedge clk);
        address = 32'h0000_0104; MEM_R_EN = 1; isHit = 1; cache_readData = 32'hDEAD_BEEF;
        #1;
        checks++; if (ready_a !== 1'b1) $display("FAIL hit_ready got %0b want 1", ready_a); else passed++;
        checks++; if (readData_a !== 32'hDEAD_BEEF) $display("FAIL hit_data got %h want deadbeef", readData_a); else passed++;
        checks++; if (LRU_update_a !== 1'b1) $display("FAIL hit_lru got %0b want 1", LRU_update_a); else passed++;
        checks++; if ({SRAM_readEn_a, SRAM_writeEn_a} !== 2'b0) $display("FAIL hit_sram got %b want 00", {SRAM_readEn_a, SRAM_writeEn_a}); else passed++;
        checks++; if (cache_address_a !== 18'h41) $display("FAIL hit_caddr got %h want 41", cache_address_a); else passed++;
        @(negedge clk);
        MEM_R_EN = 0; isHit = 0;
    endtask

    task automatic test_fill2();
        logic [31:0] wd;
        do_reset();
        @(negedge clk);
        address = 32'h0000_0104; MEM_R_EN = 1; isHit = 0;
        #1;
        checks++; if (ready_a !== 1'b0) $display("FAIL miss_ready got %0b want 0", ready_a); else passed++;
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            #1;
            checks++; if (sram_address_a !== 32'h100 + 32'(w * 4)) $display("FAIL fill2_addr%0d got %h want %h", w, sram_address_a, 32'h100 + 32'(w * 4)); else passed++;
            checks++; if (SRAM_readEn_a !== 1'b1 || ready_a !== 1'b0) $display("FAIL fill2_en%0d got rd=%0b rdy=%0b want 1 0", w, SRAM_readEn_a, ready_a); else passed++;
            repeat (2) @(negedge clk);
            wd = (w == 0) ? 32'h11 : 32'h22;
            sram_ready = 1; sram_readData = wd;
            @(negedge clk);
            sram_ready = 0;
        end
        #1;
        checks++; if (cache_writeEn_a !== 1'b1) $display("FAIL fill2_cwe got %0b want 1", cache_writeEn_a); else passed++;
        checks++; if (cache_writeData_a !== 64'h00000022_00000011) $display("FAIL fill2_line got %h want 0000002200000011", cache_writeData_a); else passed++;
        checks++; if (ready_a !== 1'b1 || readData_a !== 32'h22) $display("FAIL fill2_rd got rdy=%0b data=%h want 1 22", ready_a, readData_a); else passed++;
        @(negedge clk);
        isHit = 1; cache_readData = 32'h22;
        #1;
        checks++; if (cache_writeEn_a !== 1'b0) $display("FAIL fill2_cwe_once got %0b want 0", cache_writeEn_a); else passed++;
        checks++; if (ready_a !== 1'b1 || readData_a !== 32'h22) $display("FAIL rehit got rdy=%0b data=%h want 1 22", ready_a, readData_a); else passed++;
        @(negedge clk);
        MEM_R_EN = 0; isHit = 0;
    endtask

    task automatic test_fill8();
        logic [255:0] e8;
        do_reset();
        e8 = '0;
        for (int i = 0; i < 8; i++) e8[i*32 +: 32] = 32'hA0 + 32'(i);
        @(negedge clk);
        address = 32'h0000_001C; MEM_R_EN = 1; isHit = 0;
        @(negedge clk);
        for (int w = 0; w < 8; w++) begin
            #1;
            checks++; if (sram_address_b !== 32'(w * 4) || SRAM_readEn_b !== 1'b1)
                $display("FAIL fill8_addr%0d got %h en=%0b want %h 1", w, sram_address_b, SRAM_readEn_b, 32'(w * 4)); else passed++;
            sram_ready = 1; sram_readData = 32'hA0 + 32'(w);
            @(negedge clk);
            sram_ready = 0;
            if (w != 7) @(negedge clk);
        end
        #1;
        checks++; if (cache_writeEn_b !== 1'b1) $display("FAIL fill8_cwe got %0b want 1", cache_writeEn_b); else passed++;
        checks++; if (cache_writeData_b !== e8) $display("FAIL fill8_line got %h want %h", cache_writeData_b, e8); else passed++;
        checks++; if (ready_b !== 1'b1 || readData_b !== 32'hA7) $display("FAIL fill8_rd got rdy=%0b data=%h want 1 a7", ready_b, readData_b); else passed++;
        @(negedge clk); #1;
        checks++; if (cache_writeEn_b !== 1'b0 || ready_b !== 1'b0) $display("FAIL fill8_after got cwe=%0b rdy=%0b want 0 0", cache_writeEn_b, ready_b); else passed++;
        @(negedge clk); #1;
        checks++; if (sram_address_b !== 32'h0 || SRAM_readEn_b !== 1'b1) $display("FAIL fill8_wrap got %h en=%0b want 0 1", sram_address_b, SRAM_readEn_b); else passed++;
        MEM_R_EN = 0;
    endtask

    task automatic test_store_p0();
        do_reset();
        @(negedge clk);
        address = 32'h40; writeData = 32'h55; MEM_W_EN = 1; isHit = 0;
        #1;
        checks++; if (invalidate_a !== 1'b1 || ready_a !== 1'b0 || SRAM_writeEn_a !== 1'b0)
            $display("FAIL st0_idle got inv=%0b rdy=%0b we=%0b want 1 0 0", invalidate_a, ready_a, SRAM_writeEn_a); else passed++;
        @(negedge clk); #1;
        checks++; if (invalidate_a !== 1'b0 || SRAM_writeEn_a !== 1'b1 || ready_a !== 1'b0)
            $display("FAIL st0_write got inv=%0b we=%0b rdy=%0b want 0 1 0", invalidate_a, SRAM_writeEn_a, ready_a); else passed++;
        checks++; if (sram_address_a !== 32'h40 || sram_writeData_a !== 32'h55)
            $display("FAIL st0_bus got addr=%h data=%h want 40 55", sram_address_a, sram_writeData_a); else passed++;
        @(negedge clk); #1;
        checks++; if (SRAM_writeEn_a !== 1'b1 || ready_a !== 1'b0 || invalidate_a !== 1'b0)
            $display("FAIL st0_hold got we=%0b rdy=%0b inv=%0b want 1 0 0", SRAM_writeEn_a, ready_a, invalidate_a); else passed++;
        @(negedge clk);
        sram_ready = 1;
        #1;
        checks++; if (ready_a !== 1'b1 || SRAM_writeEn_a !== 1'b1) $display("FAIL st0_done got rdy=%0b we=%0b want 1 1", ready_a, SRAM_writeEn_a); else passed++;
        @(negedge clk);
        sram_ready = 0; MEM_W_EN = 0;
        #1;
        checks++; if (SRAM_writeEn_a !== 1'b0 || ready_a !== 1'b1) $display("FAIL st0_idle2 got we=%0b rdy=%0b want 0 1", SRAM_writeEn_a, ready_a); else passed++;
    endtask

    task automatic test_store_p1();
        do_reset();
        @(negedge clk);
        address = 32'h43; writeData = 32'h55; MEM_W_EN = 1; isHit = 1;
        #1;
        checks++; if (cache_updateEn_b !== 1'b1 || LRU_update_b !== 1'b1 || invalidate_b !== 1'b0)
            $display("FAIL st1_idle got upd=%0b lru=%0b inv=%0b want 1 1 0", cache_updateEn_b, LRU_update_b, invalidate_b); else passed++;
        @(negedge clk); #1;
        checks++; if (cache_updateEn_b !== 1'b0 || SRAM_writeEn_b !== 1'b1 || sram_address_b !== 32'h40)
            $display("FAIL st1_write got upd=%0b we=%0b addr=%h want 0 1 40", cache_updateEn_b, SRAM_writeEn_b, sram_address_b); else passed++;
        @(negedge clk);
        sram_ready = 1;
        #1;
        checks++; if (ready_b !== 1'b1 || invalidate_b !== 1'b0) $display("FAIL st1_done got rdy=%0b inv=%0b want 1 0", ready_b, invalidate_b); else passed++;
        @(negedge clk);
        sram_ready = 0; MEM_W_EN = 0; isHit = 0;
    endtask

    task automatic test_both();
        do_reset();
        @(negedge clk);
        address = 32'h80; writeData = 32'h99; MEM_R_EN = 1; MEM_W_EN = 1; isHit = 0;
        #1;
        checks++; if (invalidate_a !== 1'b1 || ready_a !== 1'b0) $display("FAIL both_idle got inv=%0b rdy=%0b want 1 0", invalidate_a, ready_a); else passed++;
        @(negedge clk); #1;
        checks++; if (SRAM_writeEn_a !== 1'b1 || SRAM_readEn_a !== 1'b0) $display("FAIL both_path got we=%0b re=%0b want 1 0", SRAM_writeEn_a, SRAM_readEn_a); else passed++;
        @(negedge clk);
        sram_ready = 1;
        #1;
        checks++; if (ready_a !== 1'b1 || SRAM_readEn_a !== 1'b0) $display("FAIL both_done got rdy=%0b re=%0b want 1 0", ready_a, SRAM_readEn_a); else passed++;
        @(negedge clk);
        sram_ready = 0; MEM_R_EN = 0; MEM_W_EN = 0;
    endtask

    task automatic test_reset_mid_fill();
        logic [127:0] e4;
        do_reset();
        @(negedge clk);
        address = 32'h0000_020C; MEM_R_EN = 1; isHit = 0;
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            sram_ready = 1; sram_readData = 32'hC0 + 32'(w);
            @(negedge clk);
            sram_ready = 0;
            @(negedge clk);
        end
        #1;
        checks++; if (cache_writeData_c !== {64'h0, 32'hC1, 32'hC0}) $display("FAIL mid_partial got %h want 00..c1c0", cache_writeData_c); else passed++;
        rst = 0;
        #1;
        checks++; if (cache_writeData_c !== 128'h0) $display("FAIL mid_clear got %h want 0", cache_writeData_c); else passed++;
        checks++; if ({SRAM_readEn_c, SRAM_writeEn_c, cache_writeEn_c, invalidate_c} !== 4'b0)
            $display("FAIL mid_en got %b want 0000", {SRAM_readEn_c, SRAM_writeEn_c, cache_writeEn_c, invalidate_c}); else passed++;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        for (int w = 0; w < 4; w++) begin
            #1;
            checks++; if (sram_address_c !== 32'h200 + 32'(w * 4)) $display("FAIL mid_addr%0d got %h want %h", w, sram_address_c, 32'h200 + 32'(w * 4)); else passed++;
            sram_ready = 1; sram_readData = 32'hD0 + 32'(w);
            @(negedge clk);
            sram_ready = 0;
            if (w != 3) @(negedge clk);
        end
        e4 = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        #1;
        checks++; if (cache_writeEn_c !== 1'b1 || cache_writeData_c !== e4) $display("FAIL mid_line got cwe=%0b %h want 1 %h", cache_writeEn_c, cache_writeData_c, e4); else passed++;
        checks++; if (readData_c !== 32'hD3 || ready_c !== 1'b1) $display("FAIL mid_rd got %h rdy=%0b want d3 1", readData_c, ready_c); else passed++;
        @(negedge clk);
        MEM_R_EN = 0;
    endtask

    initial begin
        test_reset();
        test_hit();
        test_fill2();
        test_fill8();
        test_store_p0();
        test_store_p1();
        test_both();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cache_line_ctrl.md
Name: cache_line_ctrl

Overview:
- Parametrised successor of the two-word cache controller. Sits between the MEM stage, the set-associative data cache and the SRAM controller.
- Handles read hits, multi-word line fills on read miss, and write-through stores.
- Line length and data width are generic. A selectable write policy either invalidates the line on write or updates the hit word.
- Drives a single ready/stall signal to the pipeline.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, word width in bits; power of two, at least 8.
- WORDS_PER_LINE, 2, words per cache line; power of two, at least 2.
- CACHE_ADDR_W, 18, width of the word index passed to the cache.
- WRITE_POLICY, 0: 0 = write-through, no-allocate, invalidate on write; 1 = write-through, no-allocate, update hit word.
- Derived: BOFF_W = log2(DATA_W/8); OFF_W = log2(WORDS_PER_LINE).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  MEM-stage byte address.
- writeData  in  DATA_W  store data.
- MEM_R_EN  in  1  load request.
- MEM_W_EN  in  1  store request.
- ready  out  1  1 = request complete / no stall.
- readData  out  DATA_W  load result.
- sram_readData  in  DATA_W  SRAM read word.
- sram_ready  in  1  one-cycle pulse, current SRAM access done.
- sram_address  out  ADDR_W  SRAM byte address.
- sram_writeData  out  DATA_W  SRAM write data.
- SRAM_readEn  out  1  SRAM read request, level.
- SRAM_writeEn  out  1  SRAM write request, level.
- isHit  in  1  cache hit, combinational from cache.
- cache_readData  in  DATA_W  hit word from cache.
- cache_writeEn  out  1  write the full line into the cache.
- cache_writeData  out  DATA_W*WORDS_PER_LINE  line buffer; word 0 in the LSBs.
- cache_updateEn  out  1  write one word into the hit line (policy 1 only).
- cache_address  out  CACHE_ADDR_W  address[CACHE_ADDR_W+BOFF_W-1:BOFF_W].
- LRU_update  out  1  touch LRU.
- invalidate  out  1  invalidate the line for address.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, word_cnt=0, line buffer=0. All enables, invalidate and LRU_update are 0; ready=1 when no request is present.
- States: IDLE, WRITE, FILL, LINE_WB.
- Request priority: if MEM_W_EN and MEM_R_EN are both high, the store wins.
- IDLE, no request: ready=1.
- IDLE, load with isHit=1: ready=1, readData=cache_readData, LRU_update=1, all combinational (0-cycle latency).
- IDLE, load with isHit=0 -> FILL. ready=0, word_cnt=0.
- IDLE, store -> WRITE. ready=0.
  - Policy 0: invalidate=1 for exactly that cycle.
  - Policy 1: if isHit=1, cache_updateEn=1 and LRU_update=1 for that cycle; invalidate stays 0.
- WRITE:
  - SRAM_writeEn=1; sram_address=address with byte-offset bits zeroed; sram_writeData=writeData.
  - On sram_ready: ready=1 that same cycle, then -> IDLE.
- FILL:
  - SRAM_readEn=1 throughout; sram_address={address[ADDR_W-1:OFF_W+BOFF_W], word_cnt, BOFF_W zeros}.
  - On sram_ready: buffer[word_cnt] <= sram_readData and word_cnt increments.
  - If word_cnt was WORDS_PER_LINE-1 -> LINE_WB, word_cnt wraps to 0. Otherwise stay in FILL; the next word's address is presented the following cycle with SRAM_readEn still high.
  - Fill order is always word 0 first (no critical-word-first).
- LINE_WB:
  - cache_writeEn=1 for exactly one cycle; ready=1 and readData=buffer[address offset] in the same cycle.
  - -> IDLE. A still-asserted MEM_R_EN in that IDLE cycle is treated as a new request and hits.
- The pipeline holds address, data and enables stable while ready=0. The controller does not abort on request deassertion mid-transaction; it completes the current transaction.
- sram_ready while in IDLE or LINE_WB is ignored.
- SRAM_readEn and SRAM_writeEn are never high together.
- Every output is fully assigned in every state; no latches.

Decomposition:
- Shared package cache_pkg: state encoding localparams, WRITE_POLICY codes, and a log2 helper for OFF_W/BOFF_W.
- One sub-module, line_buffer: WORDS_PER_LINE x DATA_W registers with write-enable, write index and flat read-out, async active-low clear.
- FSM and address generation stay in the top.

Test Plan:
1. Defaults; load at 0x0000_0104 with isHit=1, cache_readData=0xDEAD_BEEF -> ready=1, readData=0xDEAD_BEEF, LRU_update=1 in the same cycle, no SRAM enable.
2. Load miss at 0x0000_0104 with SRAM words 0x11, 0x22 and sram_ready after 3 cycles each:
   - sram_address 0x100 then 0x104.
   - One-cycle cache_writeEn with cache_writeData=0x00000022_00000011.
   - readData=0x22 with ready in LINE_WB.
3. WORDS_PER_LINE=8, miss at 0x1C -> eight reads at 0x00..0x1C; buffer order correct; word_cnt wraps to 0; cache_writeEn fires once.
4. Store 0x55 to 0x40, policy 0 -> invalidate pulses once, SRAM_writeEn high until sram_ready, ready on the sram_ready cycle. Repeat with policy 1 and isHit=1 -> cache_updateEn pulses, invalidate=0.
5. MEM_R_EN and MEM_W_EN both high -> WRITE path taken; no SRAM_readEn.
6. rst=0 asserted mid-FILL after word 2 of 4 -> immediately IDLE, buffer cleared, enables 0. A new miss after release restarts at word 0.
